// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: state codes, ROM selects
// and the program byte layout.
package mseq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [1:0] ROM_NONE = 2'b00;
    localparam logic [1:0] ROM_AR   = 2'b01;

    localparam logic [3:0] OP_HALT  = 4'hF;

    // Program byte: [7:6] reserved, [5:4] ROM select, [3:0] opcode.
    typedef struct packed {
        logic [1:0] rsvd;
        logic [1:0] sel;
        logic [3:0] op;
    } prog_byte_t;

    function automatic logic is_halt(input prog_byte_t b);
        return (b.sel == ROM_NONE) && (b.op == OP_HALT);
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Program-memory and ROM-bank signals of the micro sequencer.
interface micro_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pc;
    logic            prog_req;
    logic            prog_valid;
    logic [7:0]      prog_instr;
    logic [1:0]      rom_en;
    logic [7:0]      rom_instr;
    logic [7:0]      ctrl_in;

    modport master (
        output pc, prog_req, rom_en, rom_instr,
        input  prog_valid, prog_instr, ctrl_in
    );

    modport slave (
        input  pc, prog_req, rom_en, rom_instr,
        output prog_valid, prog_instr, ctrl_in
    );
endinterface

// File: rtl/micro_sequencer_hold_cnt.sv
// Hold-time down-counter: loaded with EXEC_CYCLES-1, tc marks the last hold cycle.
module mseq_hold_cnt #(
    parameter int EXEC_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam logic [3:0] LOAD_VAL = 4'(EXEC_CYCLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign tc = (cnt == 4'd0);
endmodule

// File: rtl/micro_sequencer.sv
// Microcode ROM initiator: fetch, hold select/opcode, capture control word.
// Build option MSEQ_STEP_EN adds a WAIT state released by a step pulse.
//
// state | meaning
// IDLE  | quiescent after reset, waits for start
// FETCH | prog_req high, waits for prog_valid
// EXEC  | rom_en/rom_instr held for EXEC_CYCLES cycles, capture on last
// WAIT  | single-step build only: parked until step
// HALT  | halt opcode fetched, done high, waits for start
module micro_sequencer
    import mseq_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter logic [PC_W-1:0] START_PC    = '0,
    parameter int              EXEC_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    micro_sequencer_if.master        bus,
    output logic [7:0]               ctrl_q,
    output logic                     ctrl_valid,
    output logic                     busy,
    output logic                     done
);
    logic [2:0]      state;
    logic [PC_W-1:0] pc;
    logic [1:0]      rom_en;
    logic [7:0]      rom_instr;
    prog_byte_t      fetched;
    logic            load;
    logic            hold_en;
    logic            tc;
    logic            unused_bits;

    assign fetched = prog_byte_t'(bus.prog_instr);
    assign load    = (state == ST_FETCH) && bus.prog_valid && !is_halt(fetched);
    assign hold_en = (state == ST_EXEC);

    mseq_hold_cnt #(
        .EXEC_CYCLES (EXEC_CYCLES)
    ) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (hold_en),
        .tc   (tc)
    );

    // rom_en/rom_instr double as the instruction register while in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc         <= START_PC;
            rom_en     <= ROM_NONE;
            rom_instr  <= '0;
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc    <= START_PC;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (bus.prog_valid) begin
                        if (is_halt(fetched)) begin
                            state <= ST_HALT;
                        end else begin
                            rom_en    <= fetched.sel;
                            rom_instr <= {4'b0000, fetched.op};
                            state     <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (tc) begin
                        ctrl_q     <= bus.ctrl_in;
                        ctrl_valid <= 1'b1;
                        pc         <= pc + PC_W'(1);
                        rom_en     <= ROM_NONE;
                        rom_instr  <= '0;
`ifdef MSEQ_STEP_EN
                        state      <= ST_WAIT;
`else
                        state      <= ST_FETCH;
`endif
                    end
                end
`ifdef MSEQ_STEP_EN
                ST_WAIT: begin
                    if (step) begin
                        state <= ST_FETCH;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pc        = pc;
    assign bus.prog_req  = (state == ST_FETCH);
    assign bus.rom_en    = rom_en;
    assign bus.rom_instr = rom_instr;
    assign busy          = (state inside {ST_FETCH, ST_EXEC, ST_WAIT});
    assign done          = (state == ST_HALT);

`ifdef MSEQ_STEP_EN
    assign unused_bits = ^fetched.rsvd;
`else
    assign unused_bits = ^{fetched.rsvd, step};
`endif
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: instruction-level model plus directed programs.
module tb_micro_sequencer;
    import mseq_pkg::*;

    localparam int EXEC_CYCLES = 2;
    localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_WAIT = 3, P_HALT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, step = 1'b0;
    logic [7:0] ctrl_q;
    logic       ctrl_valid, busy, done;

    logic start_w = 1'b0;
    logic step_w  = 1'b1;
    logic [7:0] ctrl_q_w;
    logic       ctrl_valid_w, busy_w, done_w;

    logic [7:0] prog_mem   [256];
    logic [7:0] prog_mem_w [256];

    int vectors = 0;
    int fails   = 0;
    bit chk_on  = 1'b0;

    int stall_pc  = -1;
    int stall_len = 0;
    logic stalling = 1'b0;

    int m_phase = P_IDLE, m_left = 0, m_pc = 0;
    logic [7:0] m_cur = 8'h00, m_ctrl = 8'h00;
    logic       m_cv = 1'b0;

    int en_cycles = 0, busy_cycles = 0;
    logic [7:0] caps[$];

    always #5 clk = ~clk;

    micro_sequencer_if #(.PC_W(8)) bus ();
    micro_sequencer_if #(.PC_W(8)) bus_w ();

    micro_sequencer #(.PC_W(8), .START_PC(8'h00), .EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .bus(bus),
        .ctrl_q(ctrl_q), .ctrl_valid(ctrl_valid), .busy(busy), .done(done)
    );

    micro_sequencer #(.PC_W(8), .START_PC(8'hFF), .EXEC_CYCLES(EXEC_CYCLES)) dut_wrap (
        .clk(clk), .rst(rst), .start(start_w), .step(step_w), .bus(bus_w),
        .ctrl_q(ctrl_q_w), .ctrl_valid(ctrl_valid_w), .busy(busy_w), .done(done_w)
    );

    // Arithmetic ROM on select 01; nothing attached elsewhere, so 0 comes back.
    function automatic logic [7:0] rom_word(input logic [1:0] sel, input logic [3:0] op);
        if (sel != ROM_AR) return 8'h00;
        case (op)
            4'h1:    return 8'h09;
            4'h3:    return 8'h0A;
            4'h6:    return 8'h21;
            4'hC:    return 8'h50;
            4'hD:    return 8'h33;
            default: return {op, ~op};
        endcase
    endfunction

    assign bus.prog_instr   = prog_mem[bus.pc];
    assign bus.prog_valid   = bus.prog_req && !stalling;
    assign bus.ctrl_in      = rom_word(bus.rom_en, bus.rom_instr[3:0]);
    assign bus_w.prog_instr = prog_mem_w[bus_w.pc];
    assign bus_w.prog_valid = bus_w.prog_req;
    assign bus_w.ctrl_in    = rom_word(bus_w.rom_en, bus_w.rom_instr[3:0]);

    always @(posedge clk) begin
        #1;
        if (bus.prog_req && int'(bus.pc) == stall_pc && stall_len > 0) begin
            stalling = 1'b1;
            stall_len--;
        end else begin
            stalling = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: what each instruction must do, cycle by cycle.
    always @(posedge clk) begin
        m_cv = 1'b0;
        if (rst) begin
            m_phase = P_IDLE; m_pc = 0; m_ctrl = 8'h00; m_cur = 8'h00; m_left = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_HALT: if (start) begin m_phase = P_FETCH; m_pc = 0; end
                P_FETCH: if (bus.prog_valid) begin
                    m_cur = prog_mem[m_pc];
                    if (m_cur[5:0] == 6'h0F) m_phase = P_HALT;
                    else begin m_phase = P_EXEC; m_left = EXEC_CYCLES; end
                end
                P_EXEC: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ctrl = rom_word(m_cur[5:4], m_cur[3:0]);
                        m_cv = 1'b1;
                        m_pc = (m_pc + 1) % 256;
`ifdef MSEQ_STEP_EN
                        m_phase = P_WAIT;
`else
                        m_phase = P_FETCH;
`endif
                    end
                end
                P_WAIT: if (step) m_phase = P_FETCH;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pc", 32'(bus.pc), 32'(m_pc));
            check("prog_req", 32'(bus.prog_req), 32'(m_phase == P_FETCH));
            check("rom_en", 32'(bus.rom_en), (m_phase == P_EXEC) ? 32'(m_cur[5:4]) : 32'd0);
            check("rom_instr", 32'(bus.rom_instr), (m_phase == P_EXEC) ? 32'(m_cur[3:0]) : 32'd0);
            check("ctrl_q", 32'(ctrl_q), 32'(m_ctrl));
            check("ctrl_valid", 32'(ctrl_valid), 32'(m_cv));
            check("busy", 32'(busy), 32'(m_phase == P_FETCH || m_phase == P_EXEC || m_phase == P_WAIT));
            check("done", 32'(done), 32'(m_phase == P_HALT));
        end
        if (bus.rom_en == ROM_AR) en_cycles++;
        if (busy) busy_cycles++;
        if (ctrl_valid) caps.push_back(ctrl_q);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        en_cycles = 0; busy_cycles = 0; caps.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    function automatic logic [7:0] cap_at(input int i);
        if (caps.size() > i) return caps[i];
        return 8'hxx;
    endfunction

    task automatic wait_done(input int max, input string name);
        int n = 0;
        while (!done && n < max) begin tick(); n++; end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_exec(input string name);
        int n = 0;
        while (bus.rom_en != ROM_AR && n < 20) begin tick(); n++; end
        check(name, 32'(bus.rom_en), 32'(ROM_AR));
    endtask

    task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        prog_mem[0] = b0; prog_mem[1] = b1; prog_mem[2] = b2; prog_mem[3] = b3;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin prog_mem[i] = 8'h0F; prog_mem_w[i] = 8'h0F; end
        prog_mem_w[8'hFF] = 8'h13;
        prog_mem_w[8'h00] = 8'h0F;

        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pc", 32'(bus.pc), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prog_req", 32'(bus.prog_req), 32'd0);
        check("rst_ctrl_q", 32'(ctrl_q), 32'd0);
        check("rst_pc_wrap", 32'(bus_w.pc), 32'hFF);

        // START_PC = FF: pc wraps to 00 after the first instruction.
        start_w = 1'b1; tick(); start_w = 1'b0;
        check("wrap_first_pc", 32'(bus_w.pc), 32'hFF);
        n = 0;
        while (!done_w && n < 20) begin tick(); n++; end
        check("wrap_done", 32'(done_w), 32'd1);
        check("wrap_pc", 32'(bus_w.pc), 32'h00);
        check("wrap_ctrl_q", 32'(ctrl_q_w), 32'h0A);

        // Basic program.
        load_prog(8'h11, 8'h1C, 8'h0F, 8'h0F);
        clear_stats();
        pulse_start();
        wait_done(40, "p1_done");
        check("p1_cap0", 32'(cap_at(0)), 32'h09);
        check("p1_cap1", 32'(cap_at(1)), 32'h50);
        check("p1_ncaps", 32'(caps.size()), 32'd2);
        check("p1_en_cycles", 32'(en_cycles), 32'd4);
        check("p1_busy_cycles", 32'(busy_cycles), 32'd7);
        check("p1_pc", 32'(bus.pc), 32'h02);

        // Same program, second fetch stalled three cycles.
        clear_stats();
        stall_pc = 1; stall_len = 3;
        pulse_start();
        wait_done(40, "p2_done");
        check("p2_cap0", 32'(cap_at(0)), 32'h09);
        check("p2_cap1", 32'(cap_at(1)), 32'h50);
        check("p2_en_cycles", 32'(en_cycles), 32'd4);
        check("p2_busy_cycles", 32'(busy_cycles), 32'd10);
        check("p2_pc", 32'(bus.pc), 32'h02);
        stall_pc = -1;

        // Reserved bits ignored, select 10 and select 00 run as NOPs returning 0.
        load_prog(8'hD1, 8'h25, 8'h03, 8'h0F);
        clear_stats();
        pulse_start();
        wait_done(40, "p3_done");
        check("p3_cap0", 32'(cap_at(0)), 32'h09);
        check("p3_cap1", 32'(cap_at(1)), 32'h00);
        check("p3_cap2", 32'(cap_at(2)), 32'h00);
        check("p3_ctrl_q", 32'(ctrl_q), 32'h00);
        check("p3_pc", 32'(bus.pc), 32'h03);
        check("p3_en_cycles", 32'(en_cycles), 32'd2);

        // Step behaviour; step raised in the capture cycle only.
        load_prog(8'h16, 8'h0F, 8'h0F, 8'h0F);
        clear_stats();
        pulse_start();
        wait_exec("p4_exec");
        tick();
        step = 1'b1; tick(); step = 1'b0;
`ifdef MSEQ_STEP_EN
        repeat (10) tick();
        check("p4_wait_busy", 32'(busy), 32'd1);
        check("p4_wait_pc", 32'(bus.pc), 32'h01);
        check("p4_wait_done", 32'(done), 32'd0);
        pulse_start();
        tick();
        check("p4_start_in_wait_pc", 32'(bus.pc), 32'h01);
        step = 1'b1; tick(); step = 1'b0;
        wait_done(10, "p4_done");
`else
        wait_done(10, "p4_done");
        check("p4_busy_cycles", 32'(busy_cycles), 32'd4);
`endif
        check("p4_cap0", 32'(cap_at(0)), 32'h21);
        check("p4_pc", 32'(bus.pc), 32'h01);

        // Reset in the second EXEC cycle, after an ignored start while busy.
        load_prog(8'h1D, 8'h0F, 8'h0F, 8'h0F);
        clear_stats();
        pulse_start();
        wait_exec("p5_exec");
        start = 1'b1; tick(); start = 1'b0;
        check("p5_exec2_en", 32'(bus.rom_en), 32'(ROM_AR));
        check("p5_exec2_pc", 32'(bus.pc), 32'h00);
        rst = 1'b1; tick(); rst = 1'b0;
        check("p5_rst_busy", 32'(busy), 32'd0);
        check("p5_rst_en", 32'(bus.rom_en), 32'(ROM_NONE));
        check("p5_rst_instr", 32'(bus.rom_instr), 32'h00);
        check("p5_rst_ctrl_q", 32'(ctrl_q), 32'h00);
        check("p5_rst_cv", 32'(ctrl_valid), 32'd0);
        tick(); tick();
        check("p5_no_caps", 32'(caps.size()), 32'd0);
        check("p5_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Initiator side of the microcode ROM interface.
- Fetches program bytes from program memory and decodes each into a ROM select (`rom_en`) and opcode (`rom_instr`).
- Holds them for a fixed number of cycles, then captures the ROM's returned control word and advances the program counter.
- Sits between program memory and the ROM bank (arithmetic ROM selected by `rom_en`=2'b01) in the 4-bit processor.

Parameters:
- PC_W, 8, program counter width; `pc` wraps modulo 2^PC_W.
- START_PC, 0, PC value loaded on reset and on every accepted start.
- EXEC_CYCLES, 2, cycles `rom_en`/`rom_instr` are held per instruction (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution from START_PC; honoured only in IDLE or HALT.
- step  in  1  single-step advance pulse; only used when MSEQ_STEP_EN is defined.
- pc  out  PC_W  program memory address.
- prog_req  out  1  fetch request; held until `prog_valid`.
- prog_valid  in  1  program byte valid this cycle.
- prog_instr  in  8  program byte: [7:6] reserved (0), [5:4] ROM select, [3:0] opcode.
- rom_en  out  2  ROM operation enable; drives the ROM `en` input.
- rom_instr  out  8  instruction to ROM: {4'b0000, opcode}.
- ctrl_in  in  8  control word returned by the ROM (combinational).
- ctrl_q  out  8  last captured control word.
- ctrl_valid  out  1  one-cycle pulse when `ctrl_q` updates.
- busy  out  1  high in FETCH, EXEC and WAIT states.
- done  out  1  high in HALT.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - state=IDLE, pc=START_PC.
  - ir, `rom_en`, `rom_instr`, `ctrl_q` = 0.
  - `prog_req`, `ctrl_valid`, `busy`, `done` = 0.
  - `cnt`=0.
  - Applies mid-instruction with no completion pulse.
- States: IDLE, FETCH, EXEC, WAIT (step builds only), HALT.
- IDLE:
  - Outputs quiescent, `rom_en`=0.
  - `start`=1 → pc<=START_PC, go to FETCH.
- FETCH:
  - `prog_req`=1, `pc` stable.
  - On `prog_valid`: ir<=prog_instr.
    - If prog_instr[5:4]==2'b00 and [3:0]==4'hF → HALT, pc unchanged.
    - Otherwise → EXEC with cnt<=EXEC_CYCLES-1.
  - Unbounded wait states on `prog_valid` are allowed.
- EXEC:
  - `rom_en`=ir[5:4], `rom_instr`={4'b0,ir[3:0]}; both registered and stable for exactly EXEC_CYCLES cycles.
  - cnt decrements each cycle.
  - On the cycle with cnt==0:
    - ctrl_q<=ctrl_in, ctrl_valid<=1 next cycle.
    - pc<=pc+1 (wraps all-ones→0).
    - → FETCH, or → WAIT when step mode is on.
  - `rom_en` returns to 0 outside EXEC.
- HALT:
  - `done`=1, `busy`=0, `ctrl_q` retained.
  - `start` → pc<=START_PC, → FETCH.
- Latency: with `prog_valid` in the first FETCH cycle, one instruction takes 1+EXEC_CYCLES cycles; `ctrl_valid` is asserted on the first FETCH cycle of the next instruction.
- `start` while `busy` is ignored.
- `step` is ignored in non-step builds.
- Opcodes with reserved bits [7:6]≠0 execute with the reserved bits ignored.
- ROM select 2'b00 with opcode ≠ F executes as a NOP: the ROM returns 0 and that 0 is captured.

Optional Feature:
- Macro: MSEQ_STEP_EN.
- Defined: after each instruction capture, enter WAIT (`busy`=1, `prog_req`=0). A `step`=1 cycle moves to FETCH. `step` asserted in the capture cycle itself is not remembered. `start` in WAIT is ignored.
- Undefined: no WAIT state; EXEC goes directly to FETCH; the `step` port exists but is unused.

Decomposition:
- Shared package `mseq_pkg`:
  - State enum (IDLE, FETCH, EXEC, WAIT, HALT).
  - ROM select constants: ROM_NONE=2'b00, ROM_AR=2'b01.
  - OP_HALT=4'hF.
  - Program byte field positions.
- Sub-module: `mseq_hold_cnt`, the EXEC_CYCLES down-counter with load/terminal-count outputs; everything else stays in the top.

Test Plan:
- Program {8'h11, 8'h1C, 8'h0F}, EXEC_CYCLES=2, ROM model = arithmetic table → `ctrl_q` becomes 8'h09 then 8'h50. Each `rom_en`=2'b01 for exactly 2 cycles. `done`=1 with pc=2.
- `prog_valid` delayed 3 cycles on the second fetch → `prog_req` and `pc` held stable, `rom_en`=0 throughout the wait, results unchanged.
- START_PC=8'hFF, program[FF]=8'h13, program[00]=8'h0F → pc wraps to 8'h00, `ctrl_q`=8'h0A, then HALT.
- `rst` asserted in the second EXEC cycle of 8'h1D → next cycle state IDLE, all outputs 0, no `ctrl_valid` pulse. `start` pulse during `busy` → no effect.
- 8'h25 (select 2'b10 with no ROM attached, `ctrl_in`=0) and 8'h03 → both captured as 8'h00, pc advances by 2.
- With MSEQ_STEP_EN: program {8'h16, 8'h0F} → `busy`=1 and pc=1 held indefinitely until a `step` pulse, then HALT. Without the macro: the same run completes in 1+2+1 cycles with no `step`.
